// File: rtl/ccsds123_sample_feeder_pkg.sv
// Shared constants and helpers for the CCSDS-123 sample feeder: lane geometry,
// counter sizing and the bubble LFSR feedback taps.
package ccsds123_pkg;

  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {ST_EMPTY, ST_HOLD} buf_state_e;

  function automatic int sb_of(input int d);
    return (d + 7) / 8;
  endfunction

  function automatic int spw_of(input int w, input int d);
    return w / (sb_of(d) * 8);
  endfunction

  function automatic int n_of(input int nx, input int ny, input int nz);
    return nx * ny * nz;
  endfunction

  // Counter width that stays at least one bit for degenerate sizes
  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ccsds123_sample_feeder_lfsr16.sv
// 16-bit Fibonacci LFSR with seed, enable and async active-low reset.
// A zero seed would lock up, so it is replaced by 1.
module lfsr16
  import ccsds123_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] value
);

  localparam logic [15:0] INIT = (SEED == 16'h0) ? 16'h0001 : SEED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  value <= INIT;
    else if (en) value <= {value[14:0], ^(value & LFSR_TAPS)};
  end

endmodule

// File: rtl/ccsds123_sample_feeder.sv
// AXI-stream front end: unpacks wide words into D-bit samples, marks image ends,
// counts images and optionally injects valid bubbles for stall testing.
module ccsds123_sample_feeder
  import ccsds123_pkg::*;
#(
  parameter int          D           = 16,
  parameter int          IN_WIDTH    = 64,
  parameter int          NX          = 16,
  parameter int          NY          = 16,
  parameter int          NZ          = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [IN_WIDTH-1:0]    s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tlast,
  output logic [D-1:0]           out_tdata,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic                   out_tlast,
  input  logic                   bubble_en,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   err_early_last
);

  localparam int SB     = sb_of(D);
  localparam int SPW    = spw_of(IN_WIDTH, D);
  localparam int N      = n_of(NX, NY, NZ);
  localparam int CNT_W  = cw_of(N);
  localparam int LANE_W = cw_of(SPW);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(N - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(SPW - 1);

  if ((IN_WIDTH % (SB * 8)) != 0 || D > 16 || D < 2) begin : g_bad_params
    $error("ccsds123_sample_feeder: illegal D/IN_WIDTH combination");
  end

  buf_state_e          st;
  logic [IN_WIDTH-1:0] word_q;
  logic [LANE_W-1:0]   lane;
  logic                word_last;
  logic [CNT_W-1:0]    cnt;   // image index of the next sample to present
  logic [15:0]         lfsr;
  logic [D-1:0]        lanes [SPW];
  logic                gate_open, load, word_done, accept, consume;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (aresetn),
    .en    (1'b1),
    .value (lfsr)
  );

  for (genvar k = 0; k < SPW; k++) begin : g_lane
    assign lanes[k] = word_q[k*SB*8 +: D];
  end

  assign gate_open = !(bubble_en && (lfsr[1:0] != 2'b00));
  assign consume   = out_tvalid && out_tready;
  assign load      = (st == ST_HOLD) && (!out_tvalid || out_tready) && gate_open;
  // Image end drops the remaining lanes so each image starts on a fresh word
  assign word_done = load && ((lane == LAST_LANE) || (cnt == LAST_CNT));
  assign s_tready  = aresetn && ((st == ST_EMPTY) || word_done);
  assign accept    = s_tvalid && s_tready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      st             <= ST_EMPTY;
      word_q         <= '0;
      lane           <= '0;
      word_last      <= 1'b0;
      cnt            <= '0;
      out_tdata      <= '0;
      out_tvalid     <= 1'b0;
      out_tlast      <= 1'b0;
      frame_count    <= '0;
      err_early_last <= 1'b0;
    end else begin
      if (load) begin
        out_tdata  <= lanes[lane];
        out_tvalid <= 1'b1;
        out_tlast  <= (cnt == LAST_CNT);
        cnt        <= (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
        lane       <= lane + LANE_W'(1);
      end else if (consume) begin
        out_tvalid <= 1'b0;
        out_tlast  <= 1'b0;
      end
      if (word_done) begin
        st <= ST_EMPTY;
        if (word_last && (cnt != LAST_CNT)) err_early_last <= 1'b1;
      end
      // A same-cycle accept overrides the lane/state update above
      if (accept) begin
        word_q    <= s_tdata;
        word_last <= s_tlast;
        lane      <= '0;
        st        <= ST_HOLD;
      end
      if (consume && out_tlast) frame_count <= frame_count + FRAME_CNT_W'(1);
    end
  end

endmodule

// File: doc/ccsds123_sample_feeder.md
# ccsds123_sample_feeder

Synthesizable AXI-stream front end for `ccsds123_top`. It accepts wide, little-endian packed raw image words, for example 64-bit words from a DMA. It unpacks them into one D-bit sample per beat, with full backpressure. It marks the last sample of each NX·NY·NZ image, counts completed images, and can inject pseudo-random valid bubbles so bench and hardware runs exercise the core under stalls.

## Interface
Parameters:
- `D`, 16: sample width in bits (2..16). SB = ceil(D/8) bytes per sample lane.
- `IN_WIDTH`, 64: input word width. Must be a multiple of SB·8. SPW = IN_WIDTH/(SB·8) samples per word.
- `NX`, `NY`, `NZ`, 16/16/8: image dimensions. Samples per image: N = NX·NY·NZ.
- `LFSR_SEED`, 16'hACE1: bubble LFSR seed. A seed of 0 is replaced by 1.
- `FRAME_CNT_W`, 16: width of the completed-image counter.

Ports:
- `clk`, in, 1: the single clock.
- `aresetn`, in, 1: asynchronous, active-low reset.
- `s_tdata`, in, IN_WIDTH: packed input word. Sample k is `s_tdata[k*SB*8 +: D]`; padding bits above D in each lane are ignored.
- `s_tvalid`, in, 1: input word valid.
- `s_tready`, out, 1: input word accepted when `s_tvalid` and `s_tready` are both high.
- `s_tlast`, in, 1: last word of the source image.
- `out_tdata`, out, D: sample to the core's `in_tdata`.
- `out_tvalid`, out, 1: sample valid.
- `out_tready`, in, 1: core ready.
- `out_tlast`, out, 1: high with sample N-1 of an image.
- `bubble_en`, in, 1: enables bubble injection. Quasi-static.
- `frame_count`, out, FRAME_CNT_W: number of completed images. Wraps.
- `err_early_last`, out, 1: sticky flag; `s_tlast` arrived before sample N-1 was reached.

## Operation
- Word buffer state machine, two states:
  - EMPTY: `s_tready`=1. An accepted word loads the buffer, sets lane index 0, and moves to HOLD.
  - HOLD: presents lanes in order 0..SPW-1.
- Output register:
  - Loads the current lane into `out_tdata`/`out_tvalid` whenever it is empty, or is being consumed this cycle, and the bubble gate is open.
  - Once `out_tvalid` is high it holds, with data stable, until `out_tready`. Bubbles never retract valid.
- Bubble gate:
  - 16-bit Fibonacci LFSR with taps 16,14,13,11, advanced every cycle after reset.
  - The gate is closed when `bubble_en` and `lfsr[1:0]`≠2'b00. This passes about 1/4 of cycles.
- Sample counter, 0..N-1, advances on every output handshake:
  - `out_tlast` = (counter==N-1) for the presented sample.
  - On the sample N-1 handshake: counter wraps to 0 and `frame_count` increments.
- Mid-word image end: lanes after sample N-1 in the same word are discarded. The buffer goes to EMPTY, so every image starts at lane 0 of a fresh word.
- Early `s_tlast`:
  - If the word carrying `s_tlast` is exhausted with counter≠N-1, set `err_early_last`.
  - The counter is not reset. The stream continues.
  - The flag clears only on reset.
- Word exhaustion: after the last lane (SPW-1) is loaded into the output register, the buffer goes to EMPTY. It may accept a new word in the same cycle; see the throughput rule below.

## Timing
- Reset values: `s_tready`=0 while `aresetn` is low, then 1 from the first cycle after release (EMPTY). `out_tvalid`=0, `out_tdata`=0, `out_tlast`=0, `frame_count`=0, `err_early_last`=0. Counter 0, lane 0, LFSR=seed.
- Latency: a word accepted at edge t presents lane 0 valid after edge t+1, with bubbles disabled.
- Throughput: 1 sample/cycle sustained. For SPW≥2 there is no gap between words: `s_tready` rises in the cycle the last lane moves to the output register.
- `s_tready` may depend combinationally on `out_tready`. No combinational path from `s_tvalid` to `out_tvalid`.
- Asynchronous reset mid-image discards the buffer and output register. The next image starts at counter 0.
- Simultaneous events: sample N-1 consumed and a new word accepted in the same cycle means the new word is lane 0 of the next image.

## Structure
- `ccsds123_pkg` holds the derived constants SB, SPW, N, the counter widths via `$clog2`, and the LFSR tap mask.
- One sub-module, `lfsr16`: seeded, enable, async reset. It is reused by benches for stall generation.
- Parameter legality is checked at elaboration: IN_WIDTH % (SB·8)==0 and D≤16.

## Test plan
- D=16, IN_WIDTH=64, NX=NY=2, NZ=1; word 0x0004_0003_0002_0001, `out_tready`=1 -> samples 1,2,3,4 on consecutive cycles, `out_tlast` with 4, `frame_count`=1.
- Same config; `out_tready` low for 3 cycles while sample 2 is presented -> `out_tdata`=2 held stable, no loss or duplication, order 1..4 preserved.
- NX=3, NY=1, NZ=1; words 0x0004_0003_0002_0001 then 0x0008_0007_0006_0005 -> outputs 1,2,3(last),5,6,7(last); sample 4 is dropped and `frame_count`=2.
- D=12; lane contents 0xF123 -> `out_tdata`=0x123.
- `bubble_en`=1 over 1000 images -> output is bit-exact against the `bubble_en`=0 run, and `out_tvalid` never falls without `out_tready`.
- NX=NY=2; `s_tlast` on a word ending at sample 2 -> `err_early_last`=1. Separately, `aresetn` pulse mid-image -> all outputs return to reset values and the next image's first sample has counter 0.
